// File: rtl/toggle_pulse_receiver.sv
// Receive end of a 2-phase toggle event link: synchronizes the toggle line,
// converts each transition into a one-cycle pulse, counts events and returns a toggle ack.
module toggle_pulse_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             cnt_clr,
    output logic             pulse,
    output logic             level,
    output logic             ack,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       evtCnt_q, evtCnt_d;
    logic                   sat_q, sat_d;
    logic                   evt;

    // Event is a difference between the synchronized level and the level already acknowledged
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], t_in};
        evt      = sync_q[SYNC_STAGES-1] ^ prev_q;
        evtCnt_d = evtCnt_q;
        sat_d    = sat_q;
        if (cnt_clr) begin
            evtCnt_d = evt ? CNT_ONE : '0;
            sat_d    = 1'b0;
        end else if (evt) begin
            if (evtCnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                evtCnt_d = evtCnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            evtCnt_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= sync_q[SYNC_STAGES-1];
            pulse_q  <= evt;
            evtCnt_q <= evtCnt_d;
            sat_q    <= sat_d;
        end
    end

    // The acknowledged level doubles as the toggle ack back to the sender
    assign ack     = prev_q;
    assign level   = sync_q[SYNC_STAGES-1];
    assign pulse   = pulse_q;
    assign evt_cnt = evtCnt_q;
    assign cnt_sat = sat_q;

endmodule

// File: tb/tb_toggle_pulse_receiver.sv
// Self-checking bench for toggle_pulse_receiver: directed scenarios plus random traffic,
// compared every cycle against an edge-indexed history model of the link.
module tb_toggle_pulse_receiver;

    localparam int N     = 2;
    localparam int CW    = 3;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          t_in = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          pulse, level, ack, cnt_sat;
    logic [CW-1:0] evt_cnt;

    int total = 0;
    int bad   = 0;

    // Model: per-edge history of sampled t_in, reset, and the resulting expected outputs
    bit x     [0:DEPTH-1];
    bit lvl   [0:DEPTH-1];
    bit ackE  [0:DEPTH-1];
    int k       = 0;
    int lastRst = 0;
    bit pulseE  = 0;
    int cntE    = 0;
    bit satE    = 0;
    bit tState  = 0;

    toggle_pulse_receiver #(.SYNC_STAGES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .t_in(t_in), .cnt_clr(cnt_clr),
        .pulse(pulse), .level(level), .ack(ack),
        .evt_cnt(evt_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare all outputs
    task automatic applyStimulus(input bit tIn, input bit clr, input bit r);
        bit evt;
        t_in    = tIn;
        cnt_clr = clr;
        rst     = r;
        @(posedge clk);
        k++;
        x[k] = tIn;
        if (r) lastRst = k;
        lvl[k] = (k - lastRst >= N) ? x[k-N+1] : 1'b0;
        evt = lvl[k-1] ^ ackE[k-1];
        if (r) begin
            ackE[k] = 0; pulseE = 0; cntE = 0; satE = 0;
        end else begin
            ackE[k] = lvl[k-1];
            pulseE  = evt;
            if (clr) begin
                cntE = evt ? 1 : 0;
                satE = 0;
            end else if (evt) begin
                if (cntE == MAXC) satE = 1;
                else cntE = cntE + 1;
            end
        end
        #1;
        checkOutput("level",   int'(level),   int'(lvl[k]));
        checkOutput("ack",     int'(ack),     int'(ackE[k]));
        checkOutput("pulse",   int'(pulse),   int'(pulseE));
        checkOutput("evt_cnt", int'(evt_cnt), cntE);
        checkOutput("cnt_sat", int'(cnt_sat), int'(satE));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(tState, 1'b0, 1'b0);
    endtask

    task automatic toggleEvery(input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            tState = ~tState;
            applyStimulus(tState, 1'b0, 1'b0);
            if (gap > 1) idle(gap - 1);
        end
    endtask

    initial begin
        x[0] = 0; lvl[0] = 0; ackE[0] = 0;
        @(negedge clk);

        // Reset then quiet
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        idle(5);

        // Single event with latency checks
        toggleEvery(1, 1);
        idle(4);

        // Event train: slow then back-to-back
        toggleEvery(4, 5);
        toggleEvery(1, 5);
        idle(4);
        checkOutput("ack_eq_tin", int'(ack), int'(tState));

        // Saturation then plain clear
        toggleEvery(2, 9);
        idle(4);
        checkOutput("sat_set", int'(cnt_sat), 1);
        applyStimulus(tState, 1'b1, 1'b0);
        idle(2);

        // Five events, then a clear coinciding with the rising pulse
        toggleEvery(2, 5);
        idle(3);
        tState = ~tState;
        applyStimulus(tState, 1'b0, 1'b0);
        applyStimulus(tState, 1'b0, 1'b0);
        applyStimulus(tState, 1'b1, 1'b0);
        checkOutput("clr_evt_cnt", int'(evt_cnt), 1);
        idle(3);

        // Mid-operation reset discards the in-flight event
        applyStimulus(tState, 1'b1, 1'b0);
        toggleEvery(2, 2);
        idle(3);
        tState = 1'b1;
        applyStimulus(tState, 1'b0, 1'b0);
        applyStimulus(tState, 1'b0, 1'b1);
        applyStimulus(tState, 1'b0, 1'b1);
        tState = 1'b0;
        idle(6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) tState = ~tState;
            applyStimulus(tState, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
